// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the control FSM and a word-wide, big-endian data memory.
// Sub-word stores do a read-modify-write. Loads return a sign- or zero-extended result.
module lsu_mem_ctrl #(
    parameter logic [5:0] MEM_PHASE = 6'b001000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_dr,
    output logic        mem_dw,
    output logic [5:0]  mem_state,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    state_t      state;
    logic        st_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] addr_q;
    logic [15:0] sdata_q;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
    endfunction

    // Byte offset 0 is the most significant byte of the word.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a, input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        case (a)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = a[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00: begin
                ext = b;
                return sx ? ext : {24'b0, b};
            end
            2'b01: begin
                ext = h;
                return sx ? ext : {16'b0, h};
            end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] a, input logic [15:0] sd);
        logic [31:0] m;
        m = w;
        if (sz == 2'b00) begin
            case (a)
                2'd0:    m[31:24] = sd[7:0];
                2'd1:    m[23:16] = sd[7:0];
                2'd2:    m[15:8]  = sd[7:0];
                default: m[7:0]   = sd[7:0];
            endcase
        end else if (a[1]) begin
            m[15:0] = sd;
        end else begin
            m[31:16] = sd;
        end
        return m;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            st_q      <= 1'b0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            addr_q    <= 32'b0;
            sdata_q   <= 16'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 32'b0;
            mem_dr    <= 1'b0;
            mem_dw    <= 1'b0;
            mem_state <= 6'b0;
            load_data <= 32'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Strobes and pulses last one cycle unless a transition re-asserts them.
            mem_dr    <= 1'b0;
            mem_dw    <= 1'b0;
            mem_state <= 6'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 32'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st_q    <= is_store;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        addr_q  <= addr;
                        sdata_q <= store_data[15:0];
                        busy    <= 1'b1;
                        if (misaligned(size, addr[1:0])) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (is_store && size == 2'b10) begin
                            state     <= WR;
                            mem_dw    <= 1'b1;
                            mem_state <= MEM_PHASE;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= store_data;
                        end else begin
                            state     <= RD;
                            mem_dr    <= 1'b1;
                            mem_state <= MEM_PHASE;
                            mem_addr  <= {addr[31:2], 2'b00};
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (st_q) begin
                        state     <= WR;
                        mem_dw    <= 1'b1;
                        mem_state <= MEM_PHASE;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        mem_wdata <= merge(mem_rdata, size_q, addr_q[1:0], sdata_q);
                    end else begin
                        state     <= FIN;
                        done      <= 1'b1;
                        load_data <= extract(mem_rdata, size_q, addr_q[1:0], sext_q);
                    end
                end
                WR: begin
                    state <= FIN;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a word memory model, directed requests with
// hand-computed results, and a monitor that checks strobes and each done pulse.
module tb_lsu_mem_ctrl;

    localparam logic [5:0] PH = 6'b001000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic [31:0] mem_rdata = 32'b0;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic        mem_dr, mem_dw, busy, done, err;
    logic [5:0]  mem_state;

    lsu_mem_ctrl #(.MEM_PHASE(PH)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .is_store(is_store), .size(size),
        .sign_ext(sign_ext), .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dr(mem_dr), .mem_dw(mem_dw),
        .mem_state(mem_state), .load_data(load_data), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'b0;

    always @(posedge CLK) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_dw) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_dr) mem_rdata <= mem[mem_addr[5:2]];
    end

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          due;
        int          rd_base;
        int          wr_base;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_maddr = 32'b0;
    logic [31:0] exp_wdata = 32'b0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: strobe contents every cycle, and one scoreboard entry per done pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (mem_dr) rd_cnt++;
            if (mem_dw) wr_cnt++;
            if (mem_dr || mem_dw) begin
                check("strobe_addr", mem_addr, exp_maddr);
                check("strobe_state", 32'(mem_state), 32'(PH));
                check("strobe_excl", 32'(mem_dr & mem_dw), 32'd0);
            end else begin
                check("quiet_state", 32'(mem_state), 32'd0);
            end
            if (mem_dw) check("wdata", mem_wdata, exp_wdata);
            else        check("wdata_zero", mem_wdata, 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("err", 32'(err), 32'(e.err));
                    check("load_data", load_data, e.ld);
                    check("latency", 32'(cyc), 32'(e.due));
                    check("rd_count", 32'(rd_cnt - e.rd_base), 32'(e.nrd));
                    check("wr_count", 32'(wr_cnt - e.wr_base), 32'(e.nwr));
                    check("busy_in_fin", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic preset(input logic [3:0] idx, input logic [31:0] val);
        @(negedge CLK);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge CLK);
        pre_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drive(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] e_wd);
        is_store = st; size = sz; sign_ext = sx; addr = a; store_data = sd;
        exp_maddr = {a[31:2], 2'b00};
        exp_wdata = e_wd;
        start = 1'b1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] sd, input logic e_err,
                         input logic [31:0] e_ld, input int lat, input int nrd, input int nwr,
                         input logic [31:0] e_wd);
        exp_t it;
        @(negedge CLK);
        drive(st, sz, sx, a, sd, e_wd);
        it = '{e_err, e_ld, cyc + lat, rd_cnt, wr_cnt, nrd, nwr};
        q.push_back(it);
        @(negedge CLK);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        exp_t it;
        int   wbase;
        int   n;

        #2 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_strobes", 32'({mem_dr, mem_dw, mem_state}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        RST_N = 1'b1;

        // Loads
        preset(4'd4, 32'h11223344);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000044, 3, 1, 0, 32'h0);
        preset(4'd4, 32'h81223344);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFF8122, 3, 1, 0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00003344, 3, 1, 0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFF81, 3, 1, 0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000022, 3, 1, 0, 32'h0);
        issue(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 32'h81223344, 3, 1, 0, 32'h0);

        // Stores (load_data must not move)
        preset(4'd4, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB, 1'b0, 32'h81223344, 4, 1, 1, 32'h11AB3344);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11AB3344, 3, 1, 0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b0, 32'h11AB3344, 4, 1, 1, 32'h11ABBEEF);
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, 1'b0, 32'h11AB3344, 4, 1, 1, 32'h11ABBE5A);
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, 1'b0, 32'h11AB3344, 2, 0, 1, 32'hCAFEF00D);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1, 0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000077, 1'b0, 32'hCAFEF00D, 4, 1, 1, 32'h77FEF00D);

        // Misaligned and illegal requests
        issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h99999999, 1'b1, 32'hCAFEF00D, 1, 0, 0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'hCAFEF00D, 1, 0, 0, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D, 1, 0, 0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000EEEE, 1'b1, 32'hCAFEF00D, 1, 0, 0, 32'h0);
        check("mem_word4", mem[4], 32'h11ABBE5A);
        check("mem_word5", mem[5], 32'h77FEF00D);

        // Reset during CAP of a half store
        wbase = wr_cnt;
        @(negedge CLK);
        drive(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000DEAD, 32'h0);
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_strobes", 32'({mem_dr, mem_dw, mem_state}), 32'd0);
        check("midrst_load_data", load_data, 32'd0);
        check("midrst_wdata", mem_wdata, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_no_write", 32'(wr_cnt - wbase), 32'd0);
        check("midrst_mem", mem[4], 32'h11ABBE5A);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000011AB, 3, 1, 0, 32'h0);

        // start held through IDLE, WR and FIN: only one word store may occur
        @(negedge CLK);
        drive(1'b1, 2'b10, 1'b0, 32'h18, 32'h600DF00D, 32'h600DF00D);
        it = '{1'b0, 32'h000011AB, cyc + 2, rd_cnt, wr_cnt, 0, 1};
        q.push_back(it);
        wbase = wr_cnt;
        repeat (3) @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        check("held_start_one_wr", 32'(wr_cnt - wbase), 32'd1);
        check("held_start_idle", 32'(busy), 32'd0);
        check("held_start_mem", mem[6], 32'h600DF00D);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
